// File: rtl/adder_bist_pkg.sv
// Shared types and constants for the adder BIST driver and its LFSR.
// Pure declarations, no timing or flow control of its own.
// Used by every module of the driver through a wildcard import.
package adder_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST_DUT,
        RUN,
        DRAIN,
        DONE
    } state_e;

    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hFFFF;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/adder_bist_if.sv
// Pin bundle between the BIST driver (master) and the adder under test (slave).
// Latency set by the adder; the driver assumes DUT_LATENCY cycles.
// No backpressure: one operand set per cycle, results expected on schedule.
interface adder_bist_if #(
    parameter int BIT_WIDTH = 4
);
    logic                 dut_n_rst;
    logic [BIT_WIDTH-1:0] a;
    logic [BIT_WIDTH-1:0] b;
    logic                 carry_in;
    logic [BIT_WIDTH-1:0] sum;
    logic                 overflow;

    modport master (
        output dut_n_rst, a, b, carry_in,
        input  sum, overflow
    );

    modport slave (
        input  dut_n_rst, a, b, carry_in,
        output sum, overflow
    );
endinterface

// File: rtl/adder_bist_lfsr.sv
// 16-bit Galois LFSR supplying random operand vectors; exposes the low OUT_W bits.
// Latency: new state one cycle after load or step.
// No backpressure: advances only when step is asserted.
module adder_bist_lfsr
    import adder_bist_pkg::*;
#(
    parameter int OUT_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [15:0]      seed,
    input  logic             step,
    output logic [OUT_W-1:0] vec
);
    logic [15:0] state;

    assign vec = state[OUT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LFSR_SEED_DEFAULT;
        end else if (load) begin
            // An all-zero seed would lock the register up.
            state <= (seed == 16'h0000) ? LFSR_SEED_DEFAULT : seed;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end
endmodule

// File: rtl/adder_bist_driver.sv
// Tester-side driver for an adder: issues exhaustive or LFSR vectors and checks results.
// Latency: result of vector t compared at the edge ending cycle t+DUT_LATENCY.
// No backpressure: one vector per RUN cycle; start while busy is ignored.
module adder_bist_driver
    import adder_bist_pkg::*;
#(
    parameter int BIT_WIDTH   = 4,
    parameter int DUT_LATENCY = 0,
    parameter int RST_CYCLES  = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             exhaustive,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic [15:0]      seed,
    adder_bist_if.master     bus,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [CNT_W-1:0] vec_count
);
    localparam int               NV         = 2 * BIT_WIDTH + 1;
    localparam int               PD         = DUT_LATENCY + 1;
    localparam logic [CNT_W-1:0] EXH_TOTAL  = CNT_W'(1) << NV;
    localparam logic [15:0]      RST_LOAD   = 16'(RST_CYCLES - 1);
    localparam logic [15:0]      DRAIN_LOAD = 16'(DUT_LATENCY);

    state_e               state;
    logic                 mode_exh;
    logic [CNT_W-1:0]     total;
    logic [15:0]          phase_cnt;
    logic [NV-1:0]        lfsr_vec;
    logic [NV-1:0]        next_vec;
    logic [BIT_WIDTH-1:0] va;
    logic [BIT_WIDTH-1:0] vb;
    logic                 vc;
    logic [BIT_WIDTH:0]   next_exp;
    logic                 accept;
    logic                 issue;
    logic                 mismatch;

    // Stage 0 describes the operands currently on the bus; stage PD-1 is the one checked.
    logic                 pipe_vld [PD];
    logic [CNT_W-1:0]     pipe_idx [PD];
    logic [BIT_WIDTH:0]   pipe_exp [PD];

    assign accept   = start && (state == IDLE || state == DONE);
    assign issue    = (state == RST_DUT && phase_cnt == 16'd0 && total != '0) ||
                      (state == RUN && vec_count != total);
    assign next_vec = mode_exh ? vec_count[NV-1:0] : lfsr_vec;
    assign {va, vb, vc} = next_vec;
    assign next_exp = {1'b0, va} + {1'b0, vb} + {{BIT_WIDTH{1'b0}}, vc};
    assign mismatch = pipe_vld[PD-1] && ({bus.overflow, bus.sum} != pipe_exp[PD-1]);

    adder_bist_lfsr #(
        .OUT_W(NV)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .seed (seed),
        .step (issue && !mode_exh),
        .vec  (lfsr_vec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            mode_exh      <= 1'b0;
            total         <= '0;
            phase_cnt     <= '0;
            bus.dut_n_rst <= 1'b0;
            bus.a         <= '0;
            bus.b         <= '0;
            bus.carry_in  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '1;
            vec_count     <= '0;
            for (int k = 0; k < PD; k++) begin
                pipe_vld[k] <= 1'b0;
                pipe_idx[k] <= '0;
                pipe_exp[k] <= '0;
            end
        end else begin
            pipe_vld[0] <= issue;
            if (issue) begin
                pipe_idx[0]  <= vec_count;
                pipe_exp[0]  <= next_exp;
                bus.a        <= va;
                bus.b        <= vb;
                bus.carry_in <= vc;
                vec_count    <= vec_count + CNT_W'(1);
            end
            for (int k = 1; k < PD; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                pipe_idx[k] <= pipe_idx[k-1];
                pipe_exp[k] <= pipe_exp[k-1];
            end

            if (mismatch) begin
                if (err_count != '1) err_count <= err_count + CNT_W'(1);
                if (err_count == '0) first_err_idx <= pipe_idx[PD-1];
            end

            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state         <= RST_DUT;
                        mode_exh      <= exhaustive;
                        total         <= exhaustive ? EXH_TOTAL : num_vectors;
                        phase_cnt     <= RST_LOAD;
                        bus.dut_n_rst <= 1'b0;
                        bus.a         <= '0;
                        bus.b         <= '0;
                        bus.carry_in  <= 1'b0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        err_count     <= '0;
                        first_err_idx <= '1;
                        vec_count     <= '0;
                        for (int k = 0; k < PD; k++) pipe_vld[k] <= 1'b0;
                    end
                end
                RST_DUT: begin
                    if (phase_cnt == 16'd0) begin
                        bus.dut_n_rst <= 1'b1;
                        if (total == '0) begin
                            state     <= DRAIN;
                            phase_cnt <= DRAIN_LOAD;
                        end else begin
                            state <= RUN;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - 16'd1;
                    end
                end
                RUN: begin
                    if (vec_count == total) begin
                        state     <= DRAIN;
                        phase_cnt <= DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    if (phase_cnt == 16'd0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !mismatch;
                    end else begin
                        phase_cnt <= phase_cnt - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_bist_driver.sv
// Bench: a combinational adder with injectable faults (LAT=0 driver) and a registered
// adder that can be shortened to one stage (LAT=2 driver), checked against a vector-list model.
module tb_adder_bist_driver;
    localparam int BUDGET = 2000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start2;
    logic        exhaustive;
    logic [15:0] num_vectors;
    logic [15:0] seed;
    int          fault0;
    bit          short2;

    logic        busy0, done0, pass0, busy2, done2, pass2;
    logic [15:0] err0, ferr0, vc0, err2, ferr2, vc2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    adder_bist_if #(.BIT_WIDTH(4)) if0 ();
    adder_bist_if #(.BIT_WIDTH(4)) if2 ();

    // Combinational adder with sum[0] / overflow stuck-at-0 faults.
    logic [4:0] t0;
    assign t0           = {1'b0, if0.a} + {1'b0, if0.b} + {4'b0, if0.carry_in};
    assign if0.sum      = (fault0 == 1) ? {t0[3:1], 1'b0} : t0[3:0];
    assign if0.overflow = (fault0 == 2) ? 1'b0 : t0[4];

    // Two-stage registered adder; short2 taps after the first stage.
    logic [4:0] r1, r2;
    always @(posedge clk) begin
        if (!if2.dut_n_rst) begin
            r1 <= 5'd0;
            r2 <= 5'd0;
        end else begin
            r1 <= {1'b0, if2.a} + {1'b0, if2.b} + {4'b0, if2.carry_in};
            r2 <= r1;
        end
    end
    assign {if2.overflow, if2.sum} = short2 ? r1 : r2;

    adder_bist_driver #(.BIT_WIDTH(4), .DUT_LATENCY(0), .RST_CYCLES(2), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .start(start0), .exhaustive(exhaustive),
        .num_vectors(num_vectors), .seed(seed), .bus(if0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .first_err_idx(ferr0), .vec_count(vc0)
    );

    adder_bist_driver #(.BIT_WIDTH(4), .DUT_LATENCY(2), .RST_CYCLES(2), .CNT_W(16)) u2 (
        .clk(clk), .rst(rst), .start(start2), .exhaustive(exhaustive),
        .num_vectors(num_vectors), .seed(seed), .bus(if2),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_err_idx(ferr2), .vec_count(vc2)
    );

    // Reference: build the vector list from the ordering rules, apply the fault to the
    // true sum, count mismatches.
    task automatic model(input bit exh, input int nv, input logic [15:0] sd, input int fault,
                         output int e_vec, output int e_err, output int e_first);
        logic [15:0] s;
        int n, vec, a, b, c, tot, ts, to, gs, go;
        s       = (sd == 16'h0) ? 16'hFFFF : sd;
        n       = exh ? 512 : nv;
        e_vec   = n;
        e_err   = 0;
        e_first = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            if (exh) vec = i;
            else begin
                vec = int'(s[8:0]);
                s   = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
            end
            a   = (vec >> 5) & 15;
            b   = (vec >> 1) & 15;
            c   = vec & 1;
            tot = a + b + c;
            ts  = tot % 16;
            to  = tot / 16;
            gs  = (fault == 1) ? (ts & 14) : ts;
            go  = (fault == 2) ? 0 : to;
            if (gs != ts || go != to) begin
                if (e_err == 0) e_first = i;
                e_err++;
            end
        end
    endtask

    // Called #1 after an edge; returns edges from the start-sampling edge to done.
    task automatic run0(input bit exh, input logic [15:0] nv, input logic [15:0] sd, output int cyc);
        exhaustive = exh; num_vectors = nv; seed = sd; start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        cyc = 0;
        while (!done0 && cyc < BUDGET) begin @(posedge clk); #1; cyc++; end
    endtask

    task automatic run2(input bit exh, input logic [15:0] nv, input logic [15:0] sd, output int cyc);
        exhaustive = exh; num_vectors = nv; seed = sd; start2 = 1'b1;
        @(posedge clk); #1; start2 = 1'b0;
        cyc = 0;
        while (!done2 && cyc < BUDGET) begin @(posedge clk); #1; cyc++; end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy0 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy0); else n_pass++;
        n_checks++; if (done0 !== 1'b0) $display("FAIL reset_done: got %b want 0", done0); else n_pass++;
        n_checks++; if (pass0 !== 1'b0) $display("FAIL reset_pass: got %b want 0", pass0); else n_pass++;
        n_checks++; if (err0 !== 16'h0) $display("FAIL reset_err: got %h want 0", err0); else n_pass++;
        n_checks++; if (ferr0 !== 16'hFFFF) $display("FAIL reset_first: got %h want ffff", ferr0); else n_pass++;
        n_checks++; if (vc0 !== 16'h0) $display("FAIL reset_vec: got %h want 0", vc0); else n_pass++;
        n_checks++; if (if0.dut_n_rst !== 1'b0) $display("FAIL reset_nrst: got %b want 0", if0.dut_n_rst); else n_pass++;
        n_checks++; if ({if0.a, if0.b, if0.carry_in} !== 9'h0) $display("FAIL reset_ops: got %h want 0", {if0.a, if0.b, if0.carry_in}); else n_pass++;
        n_checks++; if (ferr2 !== 16'hFFFF || busy2 !== 1'b0) $display("FAIL reset_u2: got first=%h busy=%b want ffff/0", ferr2, busy2); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_exhaustive(input int fault);
        int cyc, e_vec, e_err, e_first;
        fault0 = fault;
        model(1'b1, 0, 16'h0, fault, e_vec, e_err, e_first);
        run0(1'b1, 16'd0, 16'h0, cyc);
        n_checks++; if (cyc !== 515) $display("FAIL exh%0d_cycles: got %0d want 515", fault, cyc); else n_pass++;
        n_checks++; if (vc0 !== 16'(e_vec)) $display("FAIL exh%0d_vec: got %0d want %0d", fault, vc0, e_vec); else n_pass++;
        n_checks++; if (err0 !== 16'(e_err)) $display("FAIL exh%0d_err: got %0d want %0d", fault, err0, e_err); else n_pass++;
        n_checks++; if (ferr0 !== 16'(e_first)) $display("FAIL exh%0d_first: got %0d want %0d", fault, ferr0, e_first); else n_pass++;
        n_checks++; if (pass0 !== (e_err == 0)) $display("FAIL exh%0d_pass: got %b want %b", fault, pass0, e_err == 0); else n_pass++;
        fault0 = 0;
    endtask

    task automatic test_latency;
        int cyc;
        short2 = 1'b0;
        run2(1'b1, 16'd0, 16'h0, cyc);
        n_checks++; if (cyc !== 517) $display("FAIL lat2_cycles: got %0d want 517", cyc); else n_pass++;
        n_checks++; if (pass2 !== 1'b1 || err2 !== 16'h0) $display("FAIL lat2_pass: got pass=%b err=%0d want 1/0", pass2, err2); else n_pass++;
        n_checks++; if (vc2 !== 16'd512) $display("FAIL lat2_vec: got %0d want 512", vc2); else n_pass++;
        short2 = 1'b1;
        run2(1'b1, 16'd0, 16'h0, cyc);
        n_checks++; if (done2 !== 1'b1) $display("FAIL lat1_done: got %b want 1", done2); else n_pass++;
        n_checks++; if (pass2 !== 1'b0 || err2 == 16'h0) $display("FAIL lat1_detect: got pass=%b err=%0d want 0/>0", pass2, err2); else n_pass++;
        short2 = 1'b0;
    endtask

    task automatic test_random_fixed;
        int cyc, cyc_b, e_vec, e_err, e_first;
        logic [15:0] err_a;
        model(1'b0, 100, 16'hACE1, 0, e_vec, e_err, e_first);
        run0(1'b0, 16'd100, 16'hACE1, cyc);
        err_a = err0;
        n_checks++; if (cyc !== 103) $display("FAIL rnd_cycles: got %0d want 103", cyc); else n_pass++;
        n_checks++; if (vc0 !== 16'(e_vec)) $display("FAIL rnd_vec: got %0d want %0d", vc0, e_vec); else n_pass++;
        n_checks++; if (err0 !== 16'(e_err) || pass0 !== 1'b1) $display("FAIL rnd_err: got err=%0d pass=%b want %0d/1", err0, pass0, e_err); else n_pass++;
        run0(1'b0, 16'd100, 16'hACE1, cyc_b);
        n_checks++; if (cyc_b !== cyc || err0 !== err_a || vc0 !== 16'd100) $display("FAIL rnd_repeat: got cyc=%0d vec=%0d want %0d/100", cyc_b, vc0, cyc); else n_pass++;
        run2(1'b0, 16'd100, 16'hACE1, cyc);
        n_checks++; if (cyc !== 105 || pass2 !== 1'b1) $display("FAIL rnd_lat2: got cyc=%0d pass=%b want 105/1", cyc, pass2); else n_pass++;
    endtask

    task automatic test_random_sweep;
        int cyc, nv, fault, e_vec, e_err, e_first;
        logic [15:0] sd;
        for (int it = 0; it < 6; it++) begin
            nv    = (it == 0) ? 0 : $urandom_range(1, 80);
            sd    = (it == 1) ? 16'h0 : 16'($urandom);
            fault = $urandom_range(0, 2);
            fault0 = fault;
            model(1'b0, nv, sd, fault, e_vec, e_err, e_first);
            run0(1'b0, 16'(nv), sd, cyc);
            n_checks++; if (cyc !== nv + 3) $display("FAIL sweep%0d_cycles: got %0d want %0d", it, cyc, nv + 3); else n_pass++;
            n_checks++; if (vc0 !== 16'(e_vec)) $display("FAIL sweep%0d_vec: got %0d want %0d", it, vc0, e_vec); else n_pass++;
            n_checks++; if (err0 !== 16'(e_err)) $display("FAIL sweep%0d_err: got %0d want %0d", it, err0, e_err); else n_pass++;
            n_checks++; if (ferr0 !== 16'(e_first)) $display("FAIL sweep%0d_first: got %0d want %0d", it, ferr0, e_first); else n_pass++;
            n_checks++; if (pass0 !== (e_err == 0)) $display("FAIL sweep%0d_pass: got %b want %b", it, pass0, e_err == 0); else n_pass++;
        end
        fault0 = 0;
    endtask

    task automatic test_mid_reset;
        int cyc;
        fault0 = 1;
        exhaustive = 1'b1; start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        cyc = 0;
        while (vc0 != 16'd50 && cyc < BUDGET) begin @(posedge clk); #1; cyc++; end
        n_checks++; if (vc0 !== 16'd50 || err0 == 16'h0) $display("FAIL midrst_reach: got vec=%0d err=%0d want 50/>0", vc0, err0); else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) $display("FAIL midrst_flags: got busy=%b done=%b want 0/0", busy0, done0); else n_pass++;
        n_checks++; if (if0.dut_n_rst !== 1'b0) $display("FAIL midrst_nrst: got %b want 0", if0.dut_n_rst); else n_pass++;
        n_checks++; if (vc0 !== 16'h0 || err0 !== 16'h0) $display("FAIL midrst_cnt: got vec=%0d err=%0d want 0/0", vc0, err0); else n_pass++;
        n_checks++; if (ferr0 !== 16'hFFFF) $display("FAIL midrst_first: got %h want ffff", ferr0); else n_pass++;
        fault0 = 0;
        run0(1'b1, 16'd0, 16'h0, cyc);
        n_checks++; if (cyc !== 515 || pass0 !== 1'b1 || vc0 !== 16'd512) $display("FAIL midrst_rerun: got cyc=%0d pass=%b vec=%0d want 515/1/512", cyc, pass0, vc0); else n_pass++;
    endtask

    task automatic test_start_while_busy;
        int cyc;
        exhaustive = 1'b0; num_vectors = 16'd30; seed = 16'h1234; start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        cyc = 0;
        while (!done0 && cyc < BUDGET) begin
            start0 = (cyc == 10 || cyc == 31);
            @(posedge clk); #1; cyc++;
        end
        start0 = 1'b0;
        n_checks++; if (cyc !== 33) $display("FAIL busy_start_cycles: got %0d want 33", cyc); else n_pass++;
        n_checks++; if (vc0 !== 16'd30 || pass0 !== 1'b1) $display("FAIL busy_start_stats: got vec=%0d pass=%b want 30/1", vc0, pass0); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (done0 !== 1'b1 || busy0 !== 1'b0) $display("FAIL done_hold: got done=%b busy=%b want 1/0", done0, busy0); else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start0 = 1'b0; start2 = 1'b0; exhaustive = 1'b0;
        num_vectors = 16'd0; seed = 16'h0; fault0 = 0; short2 = 1'b0;
        test_reset();
        test_exhaustive(0);
        test_exhaustive(1);
        test_exhaustive(2);
        test_latency();
        test_random_fixed();
        test_random_sweep();
        test_mid_reset();
        test_start_while_busy();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
